// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared constants and mode encoding for the activation LUT pipeline
package act_pkg;

    localparam int ACT_N     = 8;
    localparam int ACT_Q     = 7;
    localparam int ACT_LANES = 2;
    localparam int SAT_W     = 16;

    typedef enum logic {
        ACT_TANH    = 1'b0,
        ACT_SIGMOID = 1'b1
    } act_mode_e;

endpackage

// File: rtl/activation_lut_pipe_if.sv
// rtl/activation_lut_pipe_if.sv - sample stream, result stream and clamp counter bundle
interface activation_lut_pipe_if
    import act_pkg::*;
#(
    parameter int N     = ACT_N,
    parameter int LANES = ACT_LANES
);
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*N-1:0]   in_data;
    logic                 in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*N-1:0]   out_data;
    logic                 sat_clr;
    logic [SAT_W-1:0]     sat_count;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready, sat_clr,
        output in_ready, out_valid, out_data, sat_count
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready, sat_clr,
        input  in_ready, out_valid, out_data, sat_count
    );
endinterface

// File: rtl/act_rom.sv
// rtl/act_rom.sv - combinational tanh magnitude table, entries built at elaboration
module act_rom #(
    parameter int N = 8,
    parameter int Q = 7
) (
    input  logic [N-2:0] k_i,
    output logic [N-2:0] t_o
);
    localparam int DEPTH = 2 ** (N - 1);
    localparam int T_MAX = 2 ** (N - 1) - 1;

    // round-half-up of tanh(k/2^Q) scaled by 2^Q, saturated to the positive range
    function automatic int tanh_entry(input int k);
        real v;
        int  r;
        v = $tanh(real'(k) / (2.0 ** Q));
        r = $rtoi($floor(v * (2.0 ** Q) + 0.5));
        if (r > T_MAX) r = T_MAX;
        return r;
    endfunction

    logic [N-2:0] rom_w [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam int V = tanh_entry(k);
        assign rom_w[k] = (N-1)'(V);
    end

    assign t_o = rom_w[k_i];
endmodule

// File: rtl/activation_lut_pipe.sv
// rtl/activation_lut_pipe.sv - two-stage tanh/sigmoid LUT pipeline; sigmoid built only with ACT_SIGMOID_EN
module activation_lut_pipe
    import act_pkg::*;
#(
    parameter int N     = ACT_N,
    parameter int Q     = ACT_Q,
    parameter int LANES = ACT_LANES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    activation_lut_pipe_if.slave bus
);
    localparam logic [N-1:0] MIN_X = {1'b1, {(N-1){1'b0}}};

    logic                     advance, accept;
    logic [LANES-1:0]         clamp_w, sign_w;
    logic [LANES-1:0][N-2:0]  t_w;
    logic [LANES-1:0][N-1:0]  res_w;

    logic                     s1_valid_q, s1_valid_d;
    logic [LANES-1:0]         s1_s_q, s1_s_d;
    logic [LANES-1:0][N-2:0]  s1_t_q, s1_t_d;
    logic                     out_valid_q, out_valid_d;
    logic [LANES-1:0][N-1:0]  out_data_q, out_data_d;
    logic [SAT_W-1:0]         sat_q, sat_d, clamp_cnt;
    logic [SAT_W:0]           sat_sum;

`ifdef ACT_SIGMOID_EN
    localparam logic signed [N+1:0] ONE_Q = (N+2)'(1) << Q;
    localparam logic signed [N+1:0] MAX_Y = (N+2)'(2 ** (N - 1) - 1);
    act_mode_e s1_mode_q, s1_mode_d;
`else
    logic unused_mode;
    assign unused_mode = bus.in_mode;
`endif

    assign advance       = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && advance;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.sat_count = sat_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [N-1:0]        x;
        logic [N-2:0]        m, k;
        logic signed [N-1:0] y;

        assign x          = bus.in_data[l*N +: N];
        assign sign_w[l]  = x[N-1];
        assign clamp_w[l] = (x == MIN_X);
        // the most negative code has no positive twin, so it is pinned to full scale
        assign m = clamp_w[l] ? {(N-1){1'b1}}
                 : x[N-1]     ? (~x[N-2:0] + (N-1)'(1))
                 :              x[N-2:0];
`ifdef ACT_SIGMOID_EN
        assign k = (act_mode_e'(bus.in_mode) == ACT_SIGMOID) ? {1'b0, m[N-2:1]} : m;
`else
        assign k = m;
`endif
        act_rom #(.N(N), .Q(Q)) u_rom (.k_i(k), .t_o(t_w[l]));

        assign y = s1_s_q[l] ? -$signed({1'b0, s1_t_q[l]}) : $signed({1'b0, s1_t_q[l]});
`ifdef ACT_SIGMOID_EN
        // sigmoid(x) = (1 + tanh(x/2)) / 2, the halved index supplied the x/2
        logic signed [N+1:0] sum;
        assign sum = (ONE_Q + $signed({{2{y[N-1]}}, y})) >>> 1;
        assign res_w[l] = (s1_mode_q != ACT_SIGMOID) ? y
                        : sum[N+1]      ? '0
                        : (sum > MAX_Y) ? MAX_Y[N-1:0]
                        :                 sum[N-1:0];
`else
        assign res_w[l] = y;
`endif
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_s_d      = s1_s_q;
        s1_t_d      = s1_t_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef ACT_SIGMOID_EN
        s1_mode_d   = s1_mode_q;
`endif
        if (advance) begin
            s1_valid_d  = bus.in_valid;
            out_valid_d = s1_valid_q;
            if (bus.in_valid) begin
                s1_s_d = sign_w;
                s1_t_d = t_w;
`ifdef ACT_SIGMOID_EN
                s1_mode_d = act_mode_e'(bus.in_mode);
`endif
            end
            if (s1_valid_q) out_data_d = res_w;
        end
    end

    always_comb begin
        clamp_cnt = '0;
        for (int l = 0; l < LANES; l++) clamp_cnt = clamp_cnt + SAT_W'(clamp_w[l]);
        sat_sum = {1'b0, sat_q} + {1'b0, clamp_cnt};
        // a clear in the same cycle as a clamp drops that clamp
        if (bus.sat_clr)  sat_d = '0;
        else if (accept)  sat_d = sat_sum[SAT_W] ? '1 : sat_sum[SAT_W-1:0];
        else              sat_d = sat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_s_q      <= '0;
            s1_t_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= '0;
`ifdef ACT_SIGMOID_EN
            s1_mode_q   <= ACT_TANH;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_s_q      <= s1_s_d;
            s1_t_q      <= s1_t_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
`ifdef ACT_SIGMOID_EN
            s1_mode_q   <= s1_mode_d;
`endif
        end
    end
endmodule
